// File: rtl/timer_pwm.sv
`default_nettype none
// ============================================================================
// Module      : timer_pwm
// Description : Compare/PWM stage behind the 8-bit timer. Double-buffered
//               duty registers, per-channel polarity/enable, flags and irq.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_pwm #(
    parameter int NCH = 4,
    parameter int DW  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic            rd_en,
    input  logic [2:0]      addr,
    input  logic [7:0]      wdata,
    output logic [7:0]      rdata,
    input  logic [DW-1:0]   tmr_cnt,
    input  logic            tmr_ovf,
    input  logic            tmr_run,
    output logic [NCH-1:0]  pwm_out,
    output logic            irq
);

    localparam logic [2:0] c_ADDR_CTRL   = 3'd4;
    localparam logic [2:0] c_ADDR_STATUS = 3'd5;
    localparam logic [2:0] c_ADDR_PEND3  = 3'd6;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } upd_state_t;

    logic [6:0]     r_ctrl;
    logic           r_ovf_flag;
    logic [NCH-1:0] r_cmp_flag;
    logic [NCH-1:0] r_pwm;
    logic           r_irq;
    logic [7:0]     r_rdata;

    logic [NCH-1:0] w_pwm_nxt;
    logic [NCH-1:0] w_cmp_set;
    logic [NCH-1:0] w_pend;
    logic [3:0]     w_pend4;
    logic [3:0]     w_cmp4;
    logic [7:0]     w_sh4 [4];
    logic           w_wr_status;
    logic [7:0]     w_rd_mux;

    assign w_wr_status = wr_en && (addr == c_ADDR_STATUS);

    generate
        for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
            upd_state_t    r_state;
            upd_state_t    w_state_nxt;
            logic [DW-1:0] r_duty_sh;
            logic [DW-1:0] r_duty_act;
            logic          w_wr;
            logic          w_load;
            logic          w_raw;

            assign w_wr   = wr_en && (addr == 3'(ch));
            // A stopped timer loads immediately; a running one waits for the wrap.
            assign w_load = (r_state == ST_PENDING) && (tmr_ovf || !tmr_run);
            assign w_raw  = (tmr_cnt < r_duty_act);

            always_comb begin
                w_state_nxt = r_state;
                case (r_state)
                    ST_IDLE:    if (w_wr) w_state_nxt = ST_PENDING;
                    ST_PENDING: if (!w_wr && w_load) w_state_nxt = ST_IDLE;
                    default:    w_state_nxt = ST_IDLE;
                endcase
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state    <= ST_IDLE;
                    r_duty_sh  <= '0;
                    r_duty_act <= '0;
                end else begin
                    r_state <= w_state_nxt;
                    if (w_load) r_duty_act <= r_duty_sh;
                    if (w_wr)   r_duty_sh  <= wdata[DW-1:0];
                end
            end

            assign w_pend[ch]    = (r_state == ST_PENDING);
            assign w_pwm_nxt[ch] = r_ctrl[ch] ? (w_raw ^ r_ctrl[4]) : r_ctrl[4];
            assign w_cmp_set[ch] = tmr_run && r_ctrl[ch] && (tmr_cnt == r_duty_act);
            assign w_pend4[ch]   = w_pend[ch];
            assign w_cmp4[ch]    = r_cmp_flag[ch];
            assign w_sh4[ch]     = 8'(r_duty_sh);
        end

        for (genvar ch = NCH; ch < 4; ch++) begin : g_pad
            assign w_pend4[ch] = 1'b0;
            assign w_cmp4[ch]  = 1'b0;
            assign w_sh4[ch]   = 8'h00;
        end
    endgenerate

    always_comb begin
        w_rd_mux = 8'h00;
        case (addr)
            3'd0, 3'd1, 3'd2, 3'd3: w_rd_mux = w_sh4[addr[1:0]];
            c_ADDR_CTRL:            w_rd_mux = {1'b0, r_ctrl};
            c_ADDR_STATUS:          w_rd_mux = {w_pend4[2:0], w_cmp4, r_ovf_flag};
            c_ADDR_PEND3:           w_rd_mux = {7'b0, w_pend4[3]};
            default:                w_rd_mux = 8'h00;
        endcase
    end

    // Flag set has priority over a simultaneous write-1-to-clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl     <= '0;
            r_ovf_flag <= 1'b0;
            r_cmp_flag <= '0;
            r_pwm      <= '0;
            r_irq      <= 1'b0;
            r_rdata    <= '0;
        end else begin
            if (wr_en && (addr == c_ADDR_CTRL)) r_ctrl <= wdata[6:0];
            r_ovf_flag <= tmr_ovf || (r_ovf_flag && !(w_wr_status && wdata[0]));
            for (int ch = 0; ch < NCH; ch++) begin
                r_cmp_flag[ch] <= w_cmp_set[ch] ||
                                  (r_cmp_flag[ch] && !(w_wr_status && wdata[ch+1]));
            end
            r_pwm <= w_pwm_nxt;
            r_irq <= (r_ovf_flag && r_ctrl[5]) || ((|r_cmp_flag) && r_ctrl[6]);
            if (rd_en) r_rdata <= w_rd_mux;
        end
    end

    assign pwm_out = r_pwm;
    assign irq     = r_irq;
    assign rdata   = r_rdata;

endmodule
`default_nettype wire

// File: doc/timer_pwm.md
Name: timer_pwm

Overview:
- Compare/PWM output stage directly downstream of the 8-bit timer.
- Consumes the timer's live count, its wrap pulse and its run bit, and produces 4 PWM channels for porta plus an interrupt.
- Software programs it through the same 8-bit register-bus style as the timer.
- Duty values are double-buffered so updates land glitch-free on period boundaries.

Parameters:
- NCH, 4, number of PWM channels (drives pwm_out width and duty register count).
- DW, 8, width of timer count and duty registers.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- wr_en  input  1  register write strobe, sampled on posedge clk.
- rd_en  input  1  register read strobe.
- addr  input  3  register address.
- wdata  input  8  write data.
- rdata  output  8  read data, registered.
- tmr_cnt  input  DW  live timer count (timer register 0).
- tmr_ovf  input  1  one-cycle pulse, high in the cycle the timer count equals period and wraps to 0.
- tmr_run  input  1  timer enable (timer control bit 7).
- pwm_out  output  NCH  PWM outputs to porta.
- irq  output  1  level interrupt.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low. All flops clear immediately on rst_n=0, independent of clk.
- Reset values: rdata=0, pwm_out=0, irq=0, all registers 0, all pending bits 0.
- Register map:
  - addr 0..3: DUTY_SH[ch], shadow duty, R/W.
  - addr 4: CTRL. [3:0] channel enable, [4] invert polarity, [5] ovf irq enable, [6] compare irq enable, [7] reserved (reads 0).
  - addr 5: STATUS. [0] OVF flag, [4:1] compare-match flag per channel, [7:5] pending-update per channel 0..2. Flags are write-1-to-clear; pending bits are read-only.
  - addr 6: PEND3. [0] pending bit for channel 3.
  - addr 7: reads 0, writes ignored.
- Read: rdata is valid the cycle after rd_en and holds its value until the next rd_en.
- Shadow write: writing DUTY_SH[ch] sets pending[ch].
- Per-channel update FSM:
  - States: IDLE, PENDING.
  - IDLE -> PENDING on a write to DUTY_SH[ch].
  - PENDING -> IDLE with DUTY_ACT[ch] <= DUTY_SH[ch] when tmr_ovf=1, or when tmr_run=0 (immediate load while the timer is stopped).
  - A write and tmr_ovf in the same cycle: the old shadow value loads into DUTY_ACT, the new value lands in the shadow, and the FSM stays in PENDING until the next ovf.
- PWM compare:
  - raw[ch] = (tmr_cnt < DUTY_ACT[ch]), unsigned DW-bit compare.
  - pwm_out[ch] registered: en[ch] ? raw[ch] ^ inv : inv. A disabled channel outputs the inactive level.
  - Latency: one clk from a tmr_cnt change to pwm_out.
  - DUTY_ACT=0 gives constant inactive. DUTY_ACT > period gives constant active.
  - With tmr_run=0, outputs hold the compare result of the frozen count.
- Flags:
  - OVF flag sets on tmr_ovf.
  - Compare flag[ch] sets in the cycle tmr_cnt == DUTY_ACT[ch] and tmr_run=1, only when en[ch]=1.
  - A set event and a W1C in the same cycle: set wins.
- irq = (OVF & CTRL[5]) | (|cmp_flags & CTRL[6]), registered, one cycle after the flag sets.
- Re-reset mid-period: outputs drop to 0 immediately. Shadow and active duty are lost; software must reprogram.
- Writes to CTRL take effect on the next cycle's pwm_out evaluation. Clearing en[ch] does not clear that channel's pending bit.

Test Plan:
- Reset: assert rst_n=0 mid-run with pwm_out=4'b0101 -> all outputs, rdata and irq are 0 asynchronously, before the next clk edge; all registers read 0 after release.
- Basic PWM: period=9, DUTY_SH0=3, timer stopped (immediate load), CTRL=0x01, then timer runs -> pwm_out[0] high for tmr_cnt 0..2, low for 3..9, delayed 1 clk; repeats every 10 clk.
- Double buffer: while running, write DUTY_SH0=7 at tmr_cnt=4 -> STATUS[5]=1; duty stays 3 until the cycle after tmr_ovf, then high for counts 0..6; pending clears.
- Boundaries: DUTY=0 -> ch low forever. DUTY=0xFF with period=9 -> ch high forever. CTRL[4]=1 -> both inverted. en=0 -> inactive level.
- Flags and irq: CTRL=0x61, DUTY0=5 -> compare flag STATUS[1] sets at cnt=5, OVF flag STATUS[0] sets at wrap, irq high; write STATUS=0x03 in the same cycle a new ovf pulses -> STATUS[0] remains 1, STATUS[1] clears.
- Collision: write DUTY_SH1=2 in the same cycle as tmr_ovf with old shadow 6 -> active=6 for the next period, active=2 after the following ovf.
